// File: rtl/seq_controller_pkg.sv
// Shared definitions for the SEQ stage sequencer: state encoding, status codes,
// stage-enable bit positions and the default reset PC.
package seq_defs;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALTED    = 3'd7
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int EN_FETCH     = 0;
  localparam int EN_DECODE    = 1;
  localparam int EN_EXECUTE   = 2;
  localparam int EN_MEMORY    = 3;
  localparam int EN_WRITEBACK = 4;
  localparam int EN_PCUPD     = 5;
  localparam int N_STAGES     = 6;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

  // One-hot enable vector for a state; IDLE and HALTED map to all-zero.
  function automatic logic [N_STAGES-1:0] stage_enables(input state_t s);
    logic [N_STAGES-1:0] en;
    en = '0;
    case (s)
      S_FETCH:     en[EN_FETCH]     = 1'b1;
      S_DECODE:    en[EN_DECODE]    = 1'b1;
      S_EXECUTE:   en[EN_EXECUTE]   = 1'b1;
      S_MEMORY:    en[EN_MEMORY]    = 1'b1;
      S_WRITEBACK: en[EN_WRITEBACK] = 1'b1;
      S_PCUPD:     en[EN_PCUPD]     = 1'b1;
      default:     en = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/seq_controller_if.sv
// Run/step/stop control handshake between a host and the SEQ sequencer,
// plus the machine status the host observes.
interface seq_controller_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             step_req;
  logic             stop;
  logic             step_ack;
  logic             running;
  logic [2:0]       stat;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output start, step_req, stop,
    input  step_ack, running, stat, instr_count
  );

  modport slave (
    input  start, step_req, stop,
    output step_ack, running, stat, instr_count
  );
endinterface

// File: rtl/seq_controller_retire_counter.sv
// Wrapping retired-instruction counter with increment and asynchronous clear.
module seq_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_controller.sv
// Y86-64 SEQ stage sequencer: owns PC and status, steps the datapath stages one
// instruction at a time under a run/step/stop handshake.
module seq_controller
  import seq_defs::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  seq_controller_if.slave    ctl,
  input  logic [63:0]        newPC,
  input  logic               halt,
  input  logic               imem_error,
  input  logic               invalid_instr,
  input  logic               dmem_error,
  output logic [63:0]        PC,
  output logic               fetch_en,
  output logic               decode_en,
  output logic               execute_en,
  output logic               memory_en,
  output logic               writeback_en,
  output logic               pcupd_en
);

  state_t              state;
  state_t              state_nxt;
  logic                run_mode;
  logic                stop_pend;
  logic                step_ack;
  logic [2:0]          stat;
  logic                fetch_exc;
  logic                retire_inc;
  logic [N_STAGES-1:0] en;

  assign fetch_exc  = imem_error | invalid_instr | halt;
  // A halt retires, so it counts even though PC never advances.
  assign retire_inc = (state == S_PCUPD) ||
                      ((state == S_FETCH) && halt && !imem_error && !invalid_instr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (ctl.start || ctl.step_req) state_nxt = S_FETCH;
      S_FETCH:     state_nxt = fetch_exc ? S_HALTED : S_DECODE;
      S_DECODE:    state_nxt = S_EXECUTE;
      S_EXECUTE:   state_nxt = S_MEMORY;
      S_MEMORY:    state_nxt = dmem_error ? S_HALTED : S_WRITEBACK;
      S_WRITEBACK: state_nxt = S_PCUPD;
      S_PCUPD:     state_nxt = (run_mode && !stop_pend) ? S_FETCH : S_IDLE;
      S_HALTED:    state_nxt = S_HALTED;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC        <= RESET_PC;
      stat      <= STAT_AOK;
      run_mode  <= 1'b0;
      stop_pend <= 1'b0;
      step_ack  <= 1'b0;
    end else begin
      step_ack <= (state == S_PCUPD) && (state_nxt == S_IDLE) && !run_mode;

      // start wins over step_req when both are present.
      if ((state == S_IDLE) && (ctl.start || ctl.step_req)) begin
        run_mode <= ctl.start;
      end

      if (state_nxt == S_IDLE) begin
        stop_pend <= 1'b0;
      end else if (ctl.stop && (state != S_IDLE) && (state != S_HALTED)) begin
        stop_pend <= 1'b1;
      end

      if (state == S_PCUPD) begin
        PC <= newPC;
      end

      if (state == S_FETCH) begin
        if (imem_error)         stat <= STAT_ADR;
        else if (invalid_instr) stat <= STAT_INS;
        else if (halt)          stat <= STAT_HLT;
      end else if ((state == S_MEMORY) && dmem_error) begin
        stat <= STAT_ADR;
      end
    end
  end

  seq_retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire_inc),
    .count (ctl.instr_count)
  );

  assign en           = stage_enables(state);
  assign fetch_en     = en[EN_FETCH];
  assign decode_en    = en[EN_DECODE];
  assign execute_en   = en[EN_EXECUTE];
  assign memory_en    = en[EN_MEMORY];
  assign writeback_en = en[EN_WRITEBACK];
  assign pcupd_en     = en[EN_PCUPD];

  assign ctl.step_ack = step_ack;
  assign ctl.stat     = stat;
  assign ctl.running  = (state != S_IDLE) && (state != S_HALTED);

endmodule

// File: tb/tb_seq_controller.sv
// Directed/randomized bench for seq_controller against an instruction-level
// reference model of PC, status, retire count and run/step/stop behaviour.
module tb_seq_controller;

  localparam logic [63:0] TB_RESET_PC = 64'h100;
  localparam int          TB_CNT_W    = 4;
  localparam int          CNT_MOD     = 1 << TB_CNT_W;

  // exception selectors for one instruction
  localparam int EX_NONE    = 0;
  localparam int EX_HALT    = 1;
  localparam int EX_IMEM    = 2;
  localparam int EX_INV     = 3;
  localparam int EX_IMEMINV = 4;
  localparam int EX_DMEM    = 5;

  logic        clk;
  logic        rst;
  logic [63:0] newPC;
  logic        halt, imem_error, invalid_instr, dmem_error;
  logic [63:0] PC;
  logic        fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en;
  logic [5:0]  en;

  seq_controller_if #(.CNT_W(TB_CNT_W)) ctl ();

  seq_controller #(
    .RESET_PC (TB_RESET_PC),
    .CNT_W    (TB_CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ctl           (ctl),
    .newPC         (newPC),
    .halt          (halt),
    .imem_error    (imem_error),
    .invalid_instr (invalid_instr),
    .dmem_error    (dmem_error),
    .PC            (PC),
    .fetch_en      (fetch_en),
    .decode_en     (decode_en),
    .execute_en    (execute_en),
    .memory_en     (memory_en),
    .writeback_en  (writeback_en),
    .pcupd_en      (pcupd_en)
  );

  assign en = {pcupd_en, writeback_en, memory_en, execute_en, decode_en, fetch_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [63:0] m_pc;
  logic [2:0]  m_stat;
  int          m_cnt;
  bit          m_run;
  bit          m_stop_pend;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ctl.start = 1'b0; ctl.step_req = 1'b0; ctl.stop = 1'b0;
    halt = 1'b0; imem_error = 1'b0; invalid_instr = 1'b0; dmem_error = 1'b0;
    newPC = {$urandom, $urandom};
  endtask

  task automatic check_arch(input string tag);
    check({tag, "_pc"},   PC, m_pc);
    check({tag, "_stat"}, 64'(ctl.stat), 64'(m_stat));
    check({tag, "_cnt"},  64'(ctl.instr_count), 64'(m_cnt));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},      PC, TB_RESET_PC);
    check({tag, "_stat"},    64'(ctl.stat), 64'd1);
    check({tag, "_cnt"},     64'(ctl.instr_count), 64'd0);
    check({tag, "_en"},      64'(en), 64'd0);
    check({tag, "_ack"},     64'(ctl.step_ack), 64'd0);
    check({tag, "_running"}, 64'(ctl.running), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    check_reset_values(tag);
    tick();
    rst = 1'b0;
    m_pc = TB_RESET_PC; m_stat = 3'd1; m_cnt = 0; m_run = 0; m_stop_pend = 0;
  endtask

  task automatic check_halted(input string tag);
    check({tag, "_en"},      64'(en), 64'd0);
    check({tag, "_running"}, 64'(ctl.running), 64'd0);
    check_arch(tag);
  endtask

  // Entry: one cycle into FETCH. Exit: one cycle into the state after PCUPD
  // (or after the exception). Returns 1 when the machine halted.
  task automatic instr(input string tag, input logic [63:0] npc, input int exc,
                       input bit stop_x, output bit halted);
    halted = 0;
    for (int s = 0; s < 6; s++) begin
      check($sformatf("%s_en%0d", tag, s), 64'(en), 64'(6'b1 << s));
      if (s == 0) begin
        check({tag, "_run"}, 64'(ctl.running), 64'd1);
        check({tag, "_ack0"}, 64'(ctl.step_ack), 64'd0);
      end
      newPC = (s == 5) ? npc : {$urandom, $urandom};
      if (s == 0) begin
        imem_error    = (exc == EX_IMEM) || (exc == EX_IMEMINV);
        invalid_instr = (exc == EX_INV)  || (exc == EX_IMEMINV);
        halt          = (exc == EX_HALT) || ((exc == EX_IMEMINV) && ($urandom_range(0, 1) == 1));
      end else begin
        halt          = 1'($urandom_range(0, 1));
        imem_error    = 1'($urandom_range(0, 1));
        invalid_instr = 1'($urandom_range(0, 1));
      end
      dmem_error = (s == 3) ? (exc == EX_DMEM) : 1'($urandom_range(0, 1));
      ctl.stop   = (s == 2) && stop_x;
      if (ctl.stop) m_stop_pend = 1;
      tick();
      clear_inputs();
      if (s == 0 && exc >= EX_HALT && exc <= EX_IMEMINV) begin
        m_stat = (exc == EX_IMEM || exc == EX_IMEMINV) ? 3'd3 :
                 (exc == EX_INV) ? 3'd4 : 3'd2;
        if (exc == EX_HALT) m_cnt = (m_cnt + 1) % CNT_MOD;
        check_halted({tag, "_fexc"});
        halted = 1;
        return;
      end
      if (s == 3 && exc == EX_DMEM) begin
        m_stat = 3'd3;
        check_halted({tag, "_mexc"});
        halted = 1;
        return;
      end
    end
    m_pc  = npc;
    m_cnt = (m_cnt + 1) % CNT_MOD;
    check_arch({tag, "_ret"});
    if (m_run && !m_stop_pend) begin
      check({tag, "_next_fetch"}, 64'(en), 64'd1);
    end else begin
      check({tag, "_idle_en"},  64'(en), 64'd0);
      check({tag, "_idle_run"}, 64'(ctl.running), 64'd0);
      check({tag, "_ack"},      64'(ctl.step_ack), 64'(!m_run));
      m_stop_pend = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    clear_inputs();
    rst = 1'b1;
    #3;
    check_reset_values("por");
    tick();
    rst = 1'b0;
    m_pc = TB_RESET_PC; m_stat = 3'd1; m_cnt = 0; m_run = 0; m_stop_pend = 0;
    tick();
    check_reset_values("idle_hold");

    // single step to 0x0A, then a few random steps
    ctl.step_req = 1'b1; tick(); ctl.step_req = 1'b0; m_run = 0;
    instr("step1", 64'h0A, EX_NONE, 0, h);
    tick();
    check("step1_ack_drop", 64'(ctl.step_ack), 64'd0);
    for (int i = 0; i < 2; i++) begin
      ctl.step_req = 1'b1; tick(); ctl.step_req = 1'b0; m_run = 0;
      instr($sformatf("rstep%0d", i), {$urandom, $urandom}, EX_NONE, 0, h);
    end

    // continuous run of 10, then stop during the 11th
    ctl.start = 1'b1; tick(); ctl.start = 1'b0; m_run = 1;
    for (int i = 0; i < 10; i++) instr($sformatf("run%0d", i), m_pc + 64'd10, EX_NONE, 0, h);
    instr("run_stop", m_pc + 64'd10, EX_NONE, 1, h);
    tick();
    check("stop_stays_idle", 64'(en), 64'd0);
    check_arch("stop_idle");

    // halt in FETCH of instruction 3, then commands ignored
    do_reset("rst_a");
    ctl.start = 1'b1; tick(); ctl.start = 1'b0; m_run = 1;
    instr("h1", m_pc + 64'd7, EX_NONE, 0, h);
    instr("h2", m_pc + 64'd7, EX_NONE, 0, h);
    instr("h3", m_pc + 64'd7, EX_HALT, 0, h);
    check("halt_flag", 64'(h), 64'd1);
    for (int i = 0; i < 4; i++) begin
      ctl.start = 1'b1; ctl.step_req = 1'($urandom_range(0, 1)); ctl.stop = 1'b1;
      tick();
      clear_inputs();
      check_halted($sformatf("halted_hold%0d", i));
    end

    // fetch-error priority
    do_reset("rst_b");
    ctl.step_req = 1'b1; tick(); ctl.step_req = 1'b0;
    instr("imeminv", {$urandom, $urandom}, EX_IMEMINV, 0, h);
    do_reset("rst_c");
    ctl.step_req = 1'b1; tick(); ctl.step_req = 1'b0;
    instr("inv", {$urandom, $urandom}, EX_INV, 0, h);

    // dmem error after one good step
    do_reset("rst_d");
    ctl.step_req = 1'b1; tick(); ctl.step_req = 1'b0;
    instr("pre_dmem", {$urandom, $urandom}, EX_NONE, 0, h);
    ctl.step_req = 1'b1; tick(); ctl.step_req = 1'b0;
    instr("dmem", {$urandom, $urandom}, EX_DMEM, 0, h);
    tick();
    check_halted("dmem_hold");

    // asynchronous reset during EXECUTE of a run
    do_reset("rst_e");
    ctl.start = 1'b1; tick(); ctl.start = 1'b0; m_run = 1;
    instr("pre_async", {$urandom, $urandom}, EX_NONE, 0, h);
    tick(); tick();
    check("in_execute", 64'(en), 64'd4);
    rst = 1'b1;
    #2;
    check_reset_values("async_rst");
    tick();
    rst = 1'b0;
    m_pc = TB_RESET_PC; m_stat = 3'd1; m_cnt = 0; m_run = 0; m_stop_pend = 0;

    // start and step_req together: run mode, no step_ack
    ctl.start = 1'b1; ctl.step_req = 1'b1; tick(); ctl.start = 1'b0; ctl.step_req = 1'b0;
    m_run = 1;
    instr("both1", {$urandom, $urandom}, EX_NONE, 0, h);
    instr("both2", {$urandom, $urandom}, EX_NONE, 1, h);

    // counter wrap: all-ones then one more retire
    do_reset("rst_f");
    ctl.start = 1'b1; tick(); ctl.start = 1'b0; m_run = 1;
    for (int i = 0; i < CNT_MOD - 1; i++) instr($sformatf("w%0d", i), {$urandom, $urandom}, EX_NONE, 0, h);
    check("cnt_all_ones", 64'(ctl.instr_count), 64'(CNT_MOD - 1));
    instr("wrap", {$urandom, $urandom}, EX_NONE, 1, h);
    check("cnt_wrapped", 64'(ctl.instr_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
# seq_controller

Stage sequencer for the Y86-64 SEQ processor. It owns the architectural PC and the processor status, and steps the fetch, decode, execute, memory, write-back and PC-update blocks through one instruction at a time using one-hot stage enables. It replaces free-running clock toggling and ad-hoc PC assignment with a run/step/stop control handshake, and records the exception status that stops the machine.

## Interface
- `RESET_PC`, default 0: PC value loaded on reset.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin continuous run; sampled in IDLE only.
- `step_req` in 1: execute exactly one instruction; sampled in IDLE only.
- `stop` in 1: in run mode, return to IDLE after the current instruction retires.
- `newPC` in 64: next PC from pc_update.
- `halt`, `imem_error`, `invalid_instr` in 1 each: fetch status, sampled in FETCH.
- `dmem_error` in 1: memory status, sampled in MEMORY.
- `PC` out 64: architectural PC presented to fetch.
- `fetch_en`, `decode_en`, `execute_en`, `memory_en`, `writeback_en`, `pcupd_en` out 1 each: one-hot stage enables.
- `step_ack` out 1: one-cycle pulse when a stepped instruction retires.
- `running` out 1: high in every state except IDLE and HALTED.
- `stat` out 3: 1 AOK, 2 HLT, 3 ADR, 4 INS.
- `instr_count` out CNT_W: number of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED. The enable for the current stage is high for that whole state. All enables are low in IDLE and HALTED.
- Mode register `run_mode`, set on leaving IDLE:
  - `start` sets it to 1.
  - `step_req` sets it to 0.
  - If both are high, `start` wins and no `step_ack` is issued.
- `stop` is latched into `stop_pend` whenever it is high in a non-IDLE state. `stop_pend` clears on entry to IDLE.
- Normal sequence: FETCH→DECODE→EXECUTE→MEMORY→WRITEBACK→PCUPD, one cycle each.
- In PCUPD:
  - `PC <= newPC` and `instr_count` increments; the counter wraps to 0 after all-ones.
  - Next state is FETCH if `run_mode` is set and `stop_pend` is not. Otherwise the next state is IDLE, with `step_ack` pulsing for one cycle in the first IDLE cycle when `run_mode` is 0.
- Exceptions sampled in FETCH, in priority order `imem_error` > `invalid_instr` > `halt`:
  - `imem_error`: `stat` becomes ADR and the next state is HALTED.
  - `invalid_instr`: `stat` becomes INS and the next state is HALTED.
  - `halt`: `stat` becomes HLT and the next state is HALTED; `instr_count` increments because halt retires.
  - In all three cases PC is unchanged and no later stage enables are asserted.
- `dmem_error` in MEMORY: `stat` becomes ADR and the next state is HALTED. WRITEBACK and PCUPD are skipped, and PC and `instr_count` are unchanged.
- HALTED is terminal. `start`, `step_req` and `stop` are ignored; only `rst` leaves it.
- Reset values: state IDLE, `PC=RESET_PC`, `stat=1` (AOK), `instr_count=0`, `run_mode=0`, `stop_pend=0`, all enables 0, `step_ack=0`, `running=0`.

## Timing
- Commands sampled at rising edge k in IDLE put the machine in FETCH during cycle k+1.
- Each instruction takes 6 cycles, so steady-state throughput is 1 instruction per 6 cycles. PC updates at the edge ending PCUPD.
- Step handshake: `step_ack` rises 7 cycles after the edge that sampled `step_req` and lasts 1 cycle. Holding `step_req` high through IDLE starts another step on the same cycle `step_ack` is high.
- Exception latency: `stat` and the HALTED state are visible in the cycle after the sampling stage. `running` drops in the same cycle.
- `rst` asserted mid-instruction forces reset values immediately, with no clock needed. A partially sequenced instruction is abandoned, and no enable stays high after reset.
- All outputs are registered or decoded from state only; no input-to-output combinational paths.

## Structure
- Shared package/header `seq_defs`:
  - State encodings.
  - STAT codes (`STAT_AOK=1`, `STAT_HLT=2`, `STAT_ADR=3`, `STAT_INS=4`).
  - Stage-enable bit positions.
  - The `RESET_PC` default.
- One sub-module, `seq_retire_counter`: a CNT_W wrapping counter with increment and async clear.
- Everything else is a single FSM plus the PC, stat and mode registers.

## Test plan
- Reset then `step_req` pulse, `newPC`=0x0A in PCUPD → enables walk fetch..pcupd over cycles 1–6; PC=0x0A; `step_ack`=1 at cycle 7; `instr_count`=1; state IDLE.
- `start` with `newPC` incrementing by 10 → after 60 cycles PC=100 and `instr_count`=10. `stop` pulsed during instruction 11's EXECUTE → it retires and the machine returns to IDLE with PC=110 and no `step_ack`.
- `halt`=1 in FETCH of instruction 3 → `stat`=2, state HALTED, `instr_count`=3, PC unchanged, later `start` ignored.
- `imem_error` and `invalid_instr` both high in FETCH → `stat`=3, no decode_en. Repeat with only `invalid_instr` → `stat`=4.
- `dmem_error` in MEMORY → `stat`=3, `writeback_en` and `pcupd_en` never assert, PC and `instr_count` unchanged.
- `rst` asserted mid-cycle during EXECUTE of a run → all outputs at reset values before the next edge. Then `start` and `step_req` together → run mode, no `step_ack`. Preload the counter to all-ones → it wraps to 0 on the next retire.
